// File: rtl/rank_select_if.sv
// Bundles the rank_select data, rank and configuration signals.
//   master : drives in_valid/in_data, ranks_in and cfg_we/cfg_k; observes results
//   slave  : the rank_select block itself
// Signals:
//   in_valid, in_data  - sample stream shifted into the window every clock
//   ranks_in           - per-slot masked ranks from the rank core (field j = slot j, 0 = masked)
//   cfg_we, cfg_k      - order-statistic write port; cfg_err flags a rejected write
//   out_valid, out_data, out_err, err_cnt - filtered result and saturating error count
interface rank_select_if #(
  parameter int unsigned N         = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RANK_BITS = $clog2(N + 1),
  parameter int unsigned CNT_W     = 8
);
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic [RANK_BITS*N-1:0] ranks_in;
  logic                   cfg_we;
  logic [RANK_BITS-1:0]   cfg_k;
  logic                   cfg_err;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_err;
  logic [CNT_W-1:0]       err_cnt;

  modport master (
    output in_valid, in_data, ranks_in, cfg_we, cfg_k,
    input  cfg_err, out_valid, out_data, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_data, ranks_in, cfg_we, cfg_k,
    output cfg_err, out_valid, out_data, out_err, err_cnt
  );
endinterface

// File: rtl/rank_select.sv
// Output stage of the masked rank-order filter.
// Holds a sample window aligned slot-for-slot with the rank core's window and, each cycle,
// picks the sample whose masked rank equals the programmed order k.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - rank_select_if slave modport (sample stream, ranks, cfg port, results)
module rank_select #(
  parameter int unsigned N         = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RANK_BITS = $clog2(N + 1),
  parameter int unsigned CNT_W     = 8
) (
  input logic          clk,
  input logic          rst,
  rank_select_if.slave bus
);

  // Slot 0 is the oldest sample, slot N-1 the newest; same indexing as ranks_in fields.
  logic [DATA_W-1:0]    win_q [N];
  logic [N-1:0]         vld_q;
  logic [RANK_BITS-1:0] k_q;

  logic                 out_valid_q;
  logic [DATA_W-1:0]    out_data_q;
  logic                 out_err_q;
  logic [CNT_W-1:0]     err_cnt_q;
  logic                 cfg_err_q;

  logic [N-1:0]         match;
  logic                 match_one;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_err;
  logic                 cfg_ok;
  logic                 cfg_bad;

  // Slots whose rank equals k; a well-formed rank vector gives exactly one.
  always_comb begin
    match = '0;
    for (int unsigned j = 0; j < N; j++) begin
      match[j] = (bus.ranks_in[j*RANK_BITS +: RANK_BITS] == k_q);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign match_one = (|match) && ~|(match & (match - N'(1)));

  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < N; j++) begin
      sel_data = sel_data | (win_q[j] & {DATA_W{match[j]}});
    end
    sel_err = ~match_one;
    if (!match_one) begin
      sel_data = '0;
    end
  end

  // k is 1-based and may not exceed the window length.
  assign cfg_ok  = bus.cfg_we && (bus.cfg_k != '0) && (32'(bus.cfg_k) <= N);
  assign cfg_bad = bus.cfg_we && !cfg_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      vld_q       <= '0;
      k_q         <= RANK_BITS'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      // Shifts unconditionally to stay in lockstep with the rank core.
      for (int unsigned i = 0; i < N - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[N-1] <= bus.in_data;
      vld_q      <= {bus.in_valid, vld_q[N-1:1]};

      out_valid_q <= &vld_q;
      out_data_q  <= sel_data;
      out_err_q   <= sel_err;

      // Counts presented error cycles; sticks at all-ones.
      if (out_valid_q && out_err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end

      // New k takes effect on the selection made in the following cycle.
      if (cfg_ok) begin
        k_q <= bus.cfg_k;
      end
      cfg_err_q <= cfg_bad;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_rank_select.sv
// Scoreboard bench for rank_select: the stimulus task plays the rank core (honest ranks from
// the current window and a mask, or deliberately corrupted ranks), predicts the registered
// response from an order-statistic model and queues it; a monitor pops and compares.
module tb_rank_select;
  localparam int unsigned N         = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RANK_BITS = 3;
  localparam int unsigned CNT_W     = 8;

  typedef struct packed {
    logic             valid;
    logic [DATA_W-1:0] data;
    logic             err;
    logic [CNT_W-1:0] cnt;
    logic             cfg_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rank_select_if #(.N(N), .DATA_W(DATA_W), .RANK_BITS(RANK_BITS), .CNT_W(CNT_W)) bus ();

  rank_select #(.N(N), .DATA_W(DATA_W), .RANK_BITS(RANK_BITS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: what the window holds now, the active k and the last predicted outputs.
  logic [DATA_W-1:0] m_data [N];
  logic              m_vld  [N];
  int                m_k;
  exp_t              m_prev;

  logic [DATA_W-1:0] seq [N] = '{8'd5, 8'd90, 8'd12, 8'd33, 8'd7, 8'd61, 8'd2};
  int                p = 0;
  int                low_cnt;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_k    = 1;
    m_prev = '0;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the state after the next rise.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic [N-1:0] mask, input bit corrupt,
                      input logic we, input logic [RANK_BITS-1:0] k);
    logic [RANK_BITS*N-1:0] rk;
    int                     vals[$];
    int                     rank;
    int                     hits;
    int                     hit_j;
    int                     ki;
    exp_t                   e;
    @(negedge clk);
    rk = '0;
    if (!r) begin
      for (int j = 0; j < N; j++) begin
        if (corrupt) begin
          rk[j*RANK_BITS +: RANK_BITS] = RANK_BITS'($urandom_range(0, 7));
        end else if (mask[j]) begin
          rank = 1;
          for (int i = 0; i < N; i++) begin
            if (mask[i] && ((m_data[i] < m_data[j]) || (m_data[i] == m_data[j] && i < j))) begin
              rank++;
            end
          end
          rk[j*RANK_BITS +: RANK_BITS] = RANK_BITS'(rank);
        end
      end
    end
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.ranks_in = rk;
    bus.cfg_we   = we;
    bus.cfg_k    = k;

    e  = '0;
    ki = int'(k);
    if (r) begin
      model_reset();
    end else begin
      e.valid = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (!m_vld[j]) e.valid = 1'b0;
      end
      if (corrupt) begin
        hits  = 0;
        hit_j = 0;
        for (int j = 0; j < N; j++) begin
          if (int'(rk[j*RANK_BITS +: RANK_BITS]) == m_k) begin
            hits++;
            hit_j = j;
          end
        end
        e.err  = (hits != 1);
        e.data = (hits == 1) ? m_data[hit_j] : '0;
      end else begin
        // k-th smallest of the unmasked samples.
        for (int j = 0; j < N; j++) begin
          if (mask[j]) vals.push_back(int'(m_data[j]));
        end
        vals.sort();
        if (m_k <= vals.size()) begin
          e.data = DATA_W'(vals[m_k-1]);
          e.err  = 1'b0;
        end else begin
          e.data = '0;
          e.err  = 1'b1;
        end
      end
      e.cnt = m_prev.cnt;
      if (m_prev.valid && m_prev.err && m_prev.cnt != 8'd255) e.cnt = m_prev.cnt + 8'd1;
      e.cfg_err = we && (ki == 0 || ki > N);
      if (we && ki >= 1 && ki <= N) m_k = ki;
      for (int i = 0; i < N - 1; i++) begin
        m_data[i] = m_data[i+1];
        m_vld[i]  = m_vld[i+1];
      end
      m_data[N-1] = d;
      m_vld[N-1]  = v;
    end
    m_prev = e;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Next sample of the repeating median pattern; any N in a row hold the same set.
  function automatic logic [DATA_W-1:0] next_seq();
    logic [DATA_W-1:0] s;
    s = seq[p % N];
    p++;
    return s;
  endfunction

  // Monitor: every presented output cycle is checked against the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_valid", bus.out_valid, mon_e.valid);
        check("out_data", bus.out_data, mon_e.data);
        check("out_err", bus.out_err, mon_e.err);
        check("err_cnt", bus.err_cnt, mon_e.cnt);
        check("cfg_err", bus.cfg_err, mon_e.cfg_err);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ranks_in = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_k    = '0;
    model_reset();

    // Reset
    repeat (3) step(1'b1, 1'b0, 8'd0, 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_cnt", bus.err_cnt, 0);

    // Warm-up: 10..70, k=4 written on the first valid edge
    for (int i = 0; i < N; i++) begin
      step(1'b0, 1'b1, DATA_W'(10 * (i + 1)), 7'h7f, 1'b0, (i == 0), 3'd4);
    end
    after_edge();
    check("warmup_7th_edge_valid", bus.out_valid, 0);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("warmup_8th_edge_valid", bus.out_valid, 1);
    check("warmup_data", bus.out_data, 40);
    check("warmup_err", bus.out_err, 0);

    // Median sweep over {5,90,12,33,7,61,2}
    repeat (N - 1) step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd1);
    after_edge();
    check("median_k4", bus.out_data, 12);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd7);
    after_edge();
    check("min_k1", bus.out_data, 2);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("max_k7", bus.out_data, 90);

    // Masked window (slots 0,2,4,6)
    step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b1, 3'd4);
    step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("masked_k4_err", bus.out_err, 0);
    step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b1, 3'd5);
    step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("masked_k5_err", bus.out_err, 1);
    check("masked_k5_data", bus.out_data, 0);
    repeat (5) step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b0, 3'd0);

    // Single-cycle bubble
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd4);
    step(1'b0, 1'b0, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
      after_edge();
      if (!bus.out_valid) low_cnt++;
    end
    check("bubble_low_cycles", low_cnt, N);
    check("bubble_resumed", bus.out_valid, 1);

    // Rejected cfg writes (cfg_k is 3 bits wide, so k=8 is not representable; 0 is the case)
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd0);
    after_edge();
    check("badcfg_pulse1", bus.cfg_err, 1);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("badcfg_drop", bus.cfg_err, 0);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd0);
    after_edge();
    check("badcfg_pulse2", bus.cfg_err, 1);
    check("badcfg_k_kept", bus.out_data, 12);

    // Error counter saturation: 4 live slots, k=7
    step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b1, 3'd7);
    repeat (280) step(1'b0, 1'b1, next_seq(), 7'h55, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("errcnt_saturated", bus.err_cnt, 255);

    // Reset mid-stream with a simultaneous cfg write
    step(1'b1, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b1, 3'd3);
    after_edge();
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_data", bus.out_data, 0);
    check("midrst_err", bus.out_err, 0);
    check("midrst_cnt", bus.err_cnt, 0);
    check("midrst_cfg_err", bus.cfg_err, 0);
    repeat (N) step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("midrst_still_low", bus.out_valid, 0);
    step(1'b0, 1'b1, next_seq(), 7'h7f, 1'b0, 1'b0, 3'd0);
    after_edge();
    check("midrst_back", bus.out_valid, 1);
    check("midrst_k1_min", bus.out_data, 2);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           DATA_W'($urandom_range(0, 255)), N'($urandom_range(0, 127)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           RANK_BITS'($urandom_range(0, 7)));
    end

    repeat (3) after_edge();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
